// File: rtl/cache_arb_pkg.sv
// Shared definitions for the cache request arbiter.
//   arb_state_e : transaction FSM encoding (IDLE/ISSUE/WAIT/RESP)
//   src_e       : response source code returned with resp_data
//   STAT_W      : width of the optional per-source statistics counters
//                 (only used when CACHE_ARB_STATS_EN is defined)
package cache_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        RESP  = 2'b11
    } arb_state_e;

    typedef enum logic [1:0] {
        SRC_L1  = 2'b00,
        SRC_L2  = 2'b01,
        SRC_MEM = 2'b10
    } src_e;

    localparam int STAT_W = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search over a request vector.
// The search starts at ptr_i and wraps; the first set bit wins.
// Ports:
//   req_i     : request vector
//   ptr_i     : index where the search starts (pointer register lives in the parent)
//   gnt_o     : one-hot grant (all zero when no request)
//   gnt_idx_o : index of the granted bit
//   any_o     : at least one request pending
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   gnt_idx_o,
    output logic               any_o
);

    int               j;
    logic [IDX_W-1:0] jj;
    logic             found;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        j         = 0;
        jj        = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            j = int'(ptr_i) + off;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            jj = IDX_W'(j);
            if (!found && req_i[jj]) begin
                found     = 1'b1;
                gnt_o[jj] = 1'b1;
                gnt_idx_o = jj;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/cache_req_arbiter.sv
// Shares one L1/L2 cache read port between NUM_REQ requesters.
// One transaction at a time, round-robin selection, result routed back
// only to the granted requester together with its source (L1/L2/memory).
//
// Optional build macro: CACHE_ARB_STATS_EN adds saturating per-source
// response counters stat_l1_cnt / stat_l2_cnt / stat_mem_cnt.
//
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   req, req_addr     : per-requester level request and packed addresses
//   gnt               : one-hot owner of the cache
//   resp_valid        : one-cycle pulse to the owner when data is ready
//   resp_data/src     : registered read data and source (00 L1, 01 L2, 10 mem)
//   busy              : high from grant through the response cycle
//   cache_read/addr   : read strobe and registered address to the cache
//   cache_read_data   : cache read data
//   cache_l1_hit/l2   : cache hit pulses
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | arbitration cycle; latch winner and its address
// ISSUE | single-cycle cache_read strobe, clear response timer
// WAIT  | wait for a hit flag or the response timeout
// RESP  | resp_valid pulses; advance round-robin pointer, release gnt
module cache_req_arbiter
    import cache_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int ADDR_WIDTH   = 11,
    parameter int DATA_WIDTH   = 32,
    parameter int RESP_TIMEOUT = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            resp_valid,
    output logic [DATA_WIDTH-1:0]         resp_data,
    output logic [1:0]                    resp_src,
    output logic                          busy,
    output logic                          cache_read,
    output logic [ADDR_WIDTH-1:0]         cache_addr,
    input  logic [DATA_WIDTH-1:0]         cache_read_data,
    input  logic                          cache_l1_hit,
    input  logic                          cache_l2_hit
`ifdef CACHE_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0]             stat_l1_cnt,
    output logic [STAT_W-1:0]             stat_l2_cnt,
    output logic [STAT_W-1:0]             stat_mem_cnt
`endif
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(RESP_TIMEOUT + 2);
    // The timer reads 0 on the first WAIT cycle, so the memory fallback is
    // taken one count past RESP_TIMEOUT; this yields RESP_TIMEOUT+3 cycles
    // from grant to resp_valid.
    localparam logic [CNT_W-1:0] TMO_CNT = CNT_W'(RESP_TIMEOUT + 1);

    arb_state_e              state_q, state_d;
    logic [IDX_W-1:0]        ptr_q, ptr_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [NUM_REQ-1:0]      gnt_q, gnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [NUM_REQ-1:0]      rv_q, rv_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    src_e                    rsrc_q, rsrc_d;

    logic [NUM_REQ-1:0]      rr_gnt;
    logic [IDX_W-1:0]        rr_idx;
    logic                    rr_any;
    logic [ADDR_WIDTH-1:0]   addr_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_addr
        assign addr_arr[g] = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req_i     (req),
        .ptr_i     (ptr_q),
        .gnt_o     (rr_gnt),
        .gnt_idx_o (rr_idx),
        .any_o     (rr_any)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        gnt_d   = gnt_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        rv_d    = '0;
        rdata_d = rdata_q;
        rsrc_d  = rsrc_q;
        case (state_q)
            IDLE: begin
                if (rr_any) begin
                    gnt_d   = rr_gnt;
                    idx_d   = rr_idx;
                    addr_d  = addr_arr[rr_idx];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // L1 has priority when both hit flags arrive together.
                if (cache_l1_hit) begin
                    rdata_d = cache_read_data;
                    rsrc_d  = SRC_L1;
                    rv_d    = gnt_q;
                    state_d = RESP;
                end else if (cache_l2_hit) begin
                    rdata_d = cache_read_data;
                    rsrc_d  = SRC_L2;
                    rv_d    = gnt_q;
                    state_d = RESP;
                end else if (cnt_q == TMO_CNT) begin
                    rdata_d = cache_read_data;
                    rsrc_d  = SRC_MEM;
                    rv_d    = gnt_q;
                    state_d = RESP;
                end
            end
            RESP: begin
                ptr_d   = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + IDX_W'(1);
                gnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            gnt_q   <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            rv_q    <= '0;
            rdata_q <= '0;
            rsrc_q  <= SRC_L1;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            gnt_q   <= gnt_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            rv_q    <= rv_d;
            rdata_q <= rdata_d;
            rsrc_q  <= rsrc_d;
        end
    end

    assign gnt        = gnt_q;
    assign resp_valid = rv_q;
    assign resp_data  = rdata_q;
    assign resp_src   = rsrc_q;
    assign busy       = (state_q != IDLE);
    assign cache_read = (state_q == ISSUE);
    assign cache_addr = addr_q;

`ifdef CACHE_ARB_STATS_EN
    logic [STAT_W-1:0] l1_cnt_q, l2_cnt_q, mem_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            l1_cnt_q  <= '0;
            l2_cnt_q  <= '0;
            mem_cnt_q <= '0;
        end else if (state_q == RESP) begin
            case (rsrc_q)
                SRC_L1:  if (l1_cnt_q  != '1) l1_cnt_q  <= l1_cnt_q  + 1'b1;
                SRC_L2:  if (l2_cnt_q  != '1) l2_cnt_q  <= l2_cnt_q  + 1'b1;
                SRC_MEM: if (mem_cnt_q != '1) mem_cnt_q <= mem_cnt_q + 1'b1;
                default: ;
            endcase
        end
    end

    assign stat_l1_cnt  = l1_cnt_q;
    assign stat_l2_cnt  = l2_cnt_q;
    assign stat_mem_cnt = mem_cnt_q;
`endif

endmodule

// File: tb/tb_cache_req_arbiter.sv
// Directed bench for cache_req_arbiter with a behavioural cache responder
// and a scoreboard of expected responses.
module tb_cache_req_arbiter;

    localparam int NR = 4;
    localparam int AW = 11;
    localparam int DW = 32;

    logic              clk;
    logic              rst;
    logic [NR-1:0]     req;
    logic [NR*AW-1:0]  req_addr;
    logic [NR-1:0]     gnt;
    logic [NR-1:0]     resp_valid;
    logic [DW-1:0]     resp_data;
    logic [1:0]        resp_src;
    logic              busy;
    logic              cache_read;
    logic [AW-1:0]     cache_addr;
    logic [DW-1:0]     cache_read_data;
    logic              cache_l1_hit;
    logic              cache_l2_hit;
`ifdef CACHE_ARB_STATS_EN
    logic [15:0]       stat_l1_cnt, stat_l2_cnt, stat_mem_cnt;
`endif

    cache_req_arbiter #(
        .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESP_TIMEOUT(3)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req             (req),
        .req_addr        (req_addr),
        .gnt             (gnt),
        .resp_valid      (resp_valid),
        .resp_data       (resp_data),
        .resp_src        (resp_src),
        .busy            (busy),
        .cache_read      (cache_read),
        .cache_addr      (cache_addr),
        .cache_read_data (cache_read_data),
        .cache_l1_hit    (cache_l1_hit),
        .cache_l2_hit    (cache_l2_hit)
`ifdef CACHE_ARB_STATS_EN
        ,
        .stat_l1_cnt     (stat_l1_cnt),
        .stat_l2_cnt     (stat_l2_cnt),
        .stat_mem_cnt    (stat_mem_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cache responder. Mode 0: no hit (memory fallback), 1: L1 hit three
    // cycles after the read strobe, 2: L2 hit four cycles after, 3: both
    // flags together three cycles after. Read data is only correct in the
    // cycle the arbiter should capture it.
    int          cm_mode;
    logic [31:0] cm_data;
    int          k;
    int          vk;

    initial begin
        cm_mode         = 0;
        cm_data         = '0;
        k               = -1;
        cache_l1_hit    = 1'b0;
        cache_l2_hit    = 1'b0;
        cache_read_data = '0;
    end

    always @(negedge clk) begin
        if (rst)             k = -1;
        else if (cache_read) k = 0;
        else if (k >= 0 && k < 50) k = k + 1;
        vk = (cm_mode == 2) ? 4 : (cm_mode == 0) ? 5 : 3;
        cache_l1_hit    = (k == 3) && (cm_mode == 1 || cm_mode == 3);
        cache_l2_hit    = ((k == 4) && cm_mode == 2) || ((k == 3) && cm_mode == 3);
        cache_read_data = (k == vk) ? cm_data : (32'h5555_0000 | 32'(k & 16'hFFFF));
    end

    typedef struct {
        int          idx;
        logic [10:0] addr;
        logic [31:0] data;
        logic [1:0]  src;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   pass_cnt;
    int   total_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push_exp(input int idx, input logic [10:0] addr, input logic [31:0] data,
                            input logic [1:0] src, input int lat);
        exp_t e;
        e.idx = idx; e.addr = addr; e.data = data; e.src = src; e.lat = lat;
        sb.push_back(e);
    endtask

    // Waits for the grant, follows the transaction to resp_valid and
    // compares against the scoreboard head. Returns on the IDLE cycle after.
    task automatic run_txn(input bit drop);
        exp_t e;
        int   lat;
        int   rd;
        bit   got;
        bit   addr_ok;
        e   = sb[0];
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (gnt != '0) begin got = 1'b1; break; end
        end
        chk("grant_seen", 64'(got), 64'd1);
        if (!got) begin void'(sb.pop_front()); return; end
        chk("gnt_onehot", 64'(gnt), 64'(1 << e.idx));
        chk("busy_at_grant", 64'(busy), 64'd1);
        lat     = 0;
        rd      = int'(cache_read);
        addr_ok = (cache_addr === e.addr);
        got     = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            rd += int'(cache_read);
            if (cache_addr !== e.addr) addr_ok = 1'b0;
            if (resp_valid != '0) begin got = 1'b1; break; end
        end
        e = sb.pop_front();
        chk("resp_seen", 64'(got), 64'd1);
        if (!got) return;
        chk("resp_valid", 64'(resp_valid), 64'(1 << e.idx));
        chk("resp_data", 64'(resp_data), 64'(e.data));
        chk("resp_src", 64'(resp_src), 64'(e.src));
        chk("latency", 64'(lat), 64'(e.lat));
        chk("read_pulses", 64'(rd), 64'd1);
        chk("addr_stable", 64'(addr_ok), 64'd1);
        chk("busy_in_resp", 64'(busy), 64'd1);
        if (drop) req = '0;
        @(negedge clk);
        chk("idle_gnt", 64'(gnt), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_resp_valid", 64'(resp_valid), 64'd0);
        chk("resp_data_hold", 64'(resp_data), 64'(e.data));
        chk("addr_hold", 64'(cache_addr), 64'(e.addr));
    endtask

    task automatic single(input int idx, input logic [10:0] addr, input int mode,
                          input logic [31:0] data, input logic [1:0] src, input int lat);
        req_addr[idx*AW +: AW] = addr;
        cm_mode = mode;
        cm_data = data;
        push_exp(idx, addr, data, src, lat);
        req = 4'(1 << idx);
        run_txn(1'b1);
    endtask

    initial begin
        bit got;
        bit quiet;
        pass_cnt  = 0;
        total_cnt = 0;
        rst       = 1'b1;
        req       = '0;
        req_addr  = '0;
        repeat (2) @(negedge clk);

        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_data", 64'(resp_data), 64'd0);
        chk("rst_resp_src", 64'(resp_src), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_cache_read", 64'(cache_read), 64'd0);
        chk("rst_cache_addr", 64'(cache_addr), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single transactions: L1, L2, memory fallback, both flags.
        single(0, 11'h010, 1, 32'h1234_5678, 2'b00, 4);
        single(1, 11'h2A0, 2, 32'hDEAD_BEEF, 2'b01, 5);
        single(2, 11'h155, 0, 32'hCAFE_BABE, 2'b10, 6);
        single(3, 11'h7FF, 3, 32'h0F0F_0F0F, 2'b00, 4);

        // All requesters held: pointer wrapped to 0, grants 0,1,2,3,0.
        for (int i = 0; i < NR; i++) req_addr[i*AW +: AW] = 11'(11'h100 + 16 * i);
        cm_mode = 1;
        req     = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            cm_data = 32'hA000_0000 | 32'(n);
            push_exp(n % NR, 11'(11'h100 + 16 * (n % NR)), 32'hA000_0000 | 32'(n), 2'b00, 4);
            run_txn(n == 4);
        end

        // Reset during WAIT of requester 1 (pointer currently 1).
        cm_mode = 0;
        cm_data = 32'h7777_7777;
        req_addr[1*AW +: AW] = 11'h3C3;
        req = 4'b0010;
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (gnt != '0) begin got = 1'b1; break; end
        end
        chk("rst_test_grant", 64'(gnt), 64'b0010);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_gnt", 64'(gnt), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_resp_valid", 64'(resp_valid), 64'd0);
        chk("midrst_cache_read", 64'(cache_read), 64'd0);
        quiet = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (resp_valid != '0 || busy) quiet = 1'b0;
        end
`ifdef CACHE_ARB_STATS_EN
        chk("stat_l1_rst", 64'(stat_l1_cnt), 64'd0);
        chk("stat_l2_rst", 64'(stat_l2_cnt), 64'd0);
        chk("stat_mem_rst", 64'(stat_mem_cnt), 64'd0);
`endif
        rst = 1'b0;
        req_addr[0*AW +: AW] = 11'h0C3;
        cm_mode = 1;
        cm_data = 32'h0BEE_F00D;
        push_exp(0, 11'h0C3, 32'h0BEE_F00D, 2'b00, 4);
        req = 4'b0011;
        run_txn(1'b1);
        chk("rst_quiet", 64'(quiet), 64'd1);

        // Two L1, one L2, one memory since reset.
        single(1, 11'h0AA, 1, 32'h1111_1111, 2'b00, 4);
        single(2, 11'h1BB, 2, 32'h2222_2222, 2'b01, 5);
        single(3, 11'h2CC, 0, 32'h3333_3333, 2'b10, 6);
`ifdef CACHE_ARB_STATS_EN
        chk("stat_l1", 64'(stat_l1_cnt), 64'd2);
        chk("stat_l2", 64'(stat_l2_cnt), 64'd1);
        chk("stat_mem", 64'(stat_mem_cnt), 64'd1);
`endif
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/cache_req_arbiter.md
Name: cache_req_arbiter

Overview:
- Shares one cache_system_4way instance (L1/L2 4-way read hierarchy) between NUM_REQ independent read requesters.
- Selects one pending requester per transaction with a round-robin grant.
- Issues a one-cycle read to the cache and holds the address stable while the transaction is in flight.
- Detects completion (L1 hit, L2 hit, or memory-fetch fallback) and returns data plus a source code to the granted requester only.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_WIDTH, 11, cache address width.
- DATA_WIDTH, 32, read data width.
- RESP_TIMEOUT, 3, cycles after issue with no hit flag before the result is taken as a memory fetch.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-high reset.
- req  input  NUM_REQ  per-requester read request; level, held until its resp_valid.
- req_addr  input  NUM_REQ*ADDR_WIDTH  packed addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- gnt  output  NUM_REQ  one-hot; the requester currently owning the cache.
- resp_valid  output  NUM_REQ  one-cycle pulse to the granted requester when data is ready.
- resp_data  output  DATA_WIDTH  read data, valid with resp_valid.
- resp_src  output  2  00 = L1, 01 = L2, 10 = memory, valid with resp_valid.
- busy  output  1  high from grant until the resp cycle, inclusive.
- cache_read  output  1  one-cycle read strobe to the cache.
- cache_addr  output  ADDR_WIDTH  registered address to the cache.
- cache_read_data  input  DATA_WIDTH  cache read_data.
- cache_l1_hit  input  1  cache l1_hit pulse.
- cache_l2_hit  input  1  cache l2_hit pulse.

Behaviour:
- Reset: all outputs 0, state IDLE, round-robin pointer 0, timeout counter 0.
- States:
  - IDLE: if any req, grant the first set bit at or after the pointer (wrapping). Latch its address into cache_addr. Set gnt and busy. Go to ISSUE.
  - ISSUE: cache_read = 1 for exactly this cycle. Clear the counter. Go to WAIT.
  - WAIT: increment the counter every cycle.
    - cache_l1_hit: capture cache_read_data, src = L1, go to RESP.
    - else cache_l2_hit: src = L2, go to RESP.
    - else counter reaches RESP_TIMEOUT: capture cache_read_data, src = MEM, go to RESP.
  - RESP: pulse resp_valid[granted] with resp_data/resp_src. Set pointer = granted+1 mod NUM_REQ. Clear gnt and busy. Return to IDLE.
- Latency from grant to resp_valid:
  - L1 hit: 4 cycles.
  - L2 hit: 5 cycles.
  - Memory: RESP_TIMEOUT+3 cycles.
- cache_addr is stable from ISSUE through RESP; it updates only at a new grant.
- One transaction at a time; minimum one IDLE cycle between transactions (arbitration cycle).
- A request deasserted before its grant is ignored.
- A request deasserted while granted: the transaction still completes; resp_valid is still pulsed and the requester must tolerate it.
- If both hit flags are high in the same cycle, L1 wins.
- Pointer wrap: after granting NUM_REQ-1, the next search starts at 0.
- Reset mid-transaction: immediate return to IDLE, outputs cleared, no resp_valid. The cache is reset by the same rst.
- resp_valid, resp_data and resp_src are registered outputs. resp_data holds its last value outside resp cycles.

Optional Feature:
- Macro CACHE_ARB_STATS_EN.
- When defined, adds three outputs, 16-bit each: stat_l1_cnt, stat_l2_cnt, stat_mem_cnt.
  - Each increments on the RESP cycle of the matching source.
  - Each saturates at 16'hFFFF and resets to 0.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package cache_arb_pkg holds:
  - state encodings IDLE/ISSUE/WAIT/RESP (2 bits);
  - source codes SRC_L1/SRC_L2/SRC_MEM;
  - the stats counter width.
- Sub-module rr_arbiter: combinational search from pointer over the req vector; outputs one-hot grant and grant index. The pointer register stays in the parent.

Test Plan:
- Reset, then req = 4'b0001, addr 0x010, cache returns l1_hit with 0x12345678 three cycles after issue -> cache_read pulses once; resp_valid = 4'b0001 4 cycles after grant; resp_data = 0x12345678; resp_src = 00.
- req = 4'b0010, addr 0x2A0, l2_hit with 0xDEADBEEF -> resp_src = 01; resp_data = 0xDEADBEEF; cache_addr held at 0x2A0 for the whole transaction.
- req = 4'b0100, no hit flags, read_data = 0xCAFEBABE -> resp_valid[2] 6 cycles after grant; resp_src = 10; resp_data = 0xCAFEBABE.
- req = 4'b1111 held, all L1 hits -> grants in order 0,1,2,3,0; each requester gets exactly one resp_valid per transaction; never two gnt bits set.
- rst asserted during WAIT of requester 1 -> gnt, busy and resp_valid go to 0 immediately; next grant after reset release goes to requester 0.
- With CACHE_ARB_STATS_EN: 2 L1, 1 L2, 1 memory transaction -> stat_l1_cnt = 2, stat_l2_cnt = 1, stat_mem_cnt = 1.
